// File: rtl/pixel_packet_receiver_pkg.sv
// Shared types and framing constants for the dibit pixel packet receiver.
package pixel_packet_receiver_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_PIXEL = 2'd2,
      ST_DRAIN = 2'd3
   } rx_state_e;

   localparam int ADDR_DIBITS      = 12;
   localparam int DIBITS_PER_PIXEL = 4;
   localparam int PIX_W            = 2 * DIBITS_PER_PIXEL;
endpackage

// File: rtl/pixel_packet_receiver_dibit_deserializer.sv
// LSB-first dibit shift register; word_o is the completed word in the cycle full_o is high.
module dibit_deserializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         shift_i,
   input  logic [1:0]   din_i,
   output logic [W-1:0] word_o,
   output logic         full_o,
   output logic         busy_o
);
   localparam int N  = W / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Only the first N-1 dibits are stored; the final one is taken straight from din_i.
   logic [W-3:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign word_o = {din_i, data_q};
   assign full_o = shift_i && (cnt_q == LAST);
   assign busy_o = (cnt_q != '0);

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (shift_i) begin
         data_d = {din_i, data_q[W-3:2]};
         cnt_d  = full_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/pixel_packet_receiver.sv
// Receives address + pixel packets as a dibit stream and emits frame-buffer writes.
module pixel_packet_receiver
   import pixel_packet_receiver_pkg::*;
#(
   parameter int FRAME_PIXELS = 76800,
   parameter int ADDR_W       = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              axiiv,
   input  logic [1:0]        axiid,
   output logic [7:0]        pixel_out,
   output logic [ADDR_W-1:0] pixel_addr_out,
   output logic              pixel_we,
   output logic              pkt_done,
   output logic              pkt_err
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   rx_state_e         state_q, state_d;
   logic              armed_q;
   logic [ADDR_W-1:0] addr_q, addr_d, paddr_q, paddr_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              we_q, we_d, done_q, done_d, err_q, err_d;

   logic              addr_shift, addr_full, addr_busy, addr_ok;
   logic              pix_shift, pix_full, pix_busy;
   logic [ADDR_W-1:0] addr_word;
   logic [PIX_W-1:0]  pix_word;

   // After reset the receiver stays deaf until it has seen axiiv low once.
   assign addr_shift = axiiv && ((state_q == ST_IDLE && armed_q) || state_q == ST_ADDR);
   assign pix_shift  = axiiv && (state_q == ST_PIXEL);
   assign addr_ok    = ({1'b0, addr_word} < (ADDR_W + 1)'(FRAME_PIXELS));

   dibit_deserializer #(.W(ADDR_W)) u_addr_deser (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (!axiiv),
      .shift_i (addr_shift),
      .din_i   (axiid),
      .word_o  (addr_word),
      .full_o  (addr_full),
      .busy_o  (addr_busy)
   );

   dibit_deserializer #(.W(PIX_W)) u_pix_deser (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (!axiiv),
      .shift_i (pix_shift),
      .din_i   (axiid),
      .word_o  (pix_word),
      .full_o  (pix_full),
      .busy_o  (pix_busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_q | ~axiiv;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (axiiv && armed_q) state_d = ST_ADDR;
         ST_ADDR: begin
            if (!axiiv)         state_d = ST_IDLE;
            else if (addr_full) state_d = addr_ok ? ST_PIXEL : ST_DRAIN;
         end
         ST_PIXEL: if (!axiiv) state_d = ST_IDLE;
         ST_DRAIN: if (!axiiv) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      paddr_d = paddr_q;
      pix_d   = pix_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_ADDR: begin
            if (!axiiv) begin
               err_d = addr_busy;
            end else if (addr_full) begin
               if (addr_ok) addr_d = addr_word;
               else         err_d  = 1'b1;
            end
         end
         ST_PIXEL: begin
            if (!axiiv) begin
               err_d  = pix_busy;
               done_d = !pix_busy;
            end else if (pix_full) begin
               we_d    = 1'b1;
               pix_d   = pix_word;
               paddr_d = addr_q;
               addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         paddr_q <= '0;
         pix_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         paddr_q <= paddr_d;
         pix_q   <= pix_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign pixel_out      = pix_q;
   assign pixel_addr_out = paddr_q;
   assign pixel_we       = we_q;
   assign pkt_done       = done_q;
   assign pkt_err        = err_q;
endmodule

// File: tb/tb_pixel_packet_receiver.sv
// Bench: directed table + randomized packets scored against an event-level packet model.
module tb_pixel_packet_receiver;
   localparam int FP = 76800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        axiiv = 1'b0;
   logic [1:0]  axiid = 2'b00;
   logic [7:0]  pixel_out;
   logic [23:0] pixel_addr_out;
   logic        pixel_we, pkt_done, pkt_err;

   pixel_packet_receiver #(.FRAME_PIXELS(FP), .ADDR_W(24)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .axiiv          (axiiv),
      .axiid          (axiid),
      .pixel_out      (pixel_out),
      .pixel_addr_out (pixel_addr_out),
      .pixel_we       (pixel_we),
      .pkt_done       (pkt_done),
      .pkt_err        (pkt_err)
   );

   always #5 clk = ~clk;

   // kind: 0 = write, 1 = done, 2 = err
   typedef struct {int cyc; int kind; int a; int d;} ev_t;
   typedef struct {
      int a; int adib; int np; logic [7:0] p0; logic [7:0] p1; int extra; int gap;
      int e_we; int e_done; int e_err; int e_la; int e_ld;
   } vec_t;

   ev_t        act_q[$], exp_q[$];
   logic [7:0] pix_q[$];
   logic [1:0] rq[$];
   vec_t       tbl[8];
   int cyc = 0, n_we = 0, n_done = 0, n_err = 0, n_chk = 0, n_fail = 0;

   function automatic ev_t mk(input int c, input int k, input int a, input int d);
      ev_t e;
      e.cyc = c; e.kind = k; e.a = a; e.d = d;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (pixel_we) begin act_q.push_back(mk(cyc, 0, int'(pixel_addr_out), int'(pixel_out))); n_we++; end
      if (pkt_done) begin act_q.push_back(mk(cyc, 1, 0, 0)); n_done++; end
      if (pkt_err)  begin act_q.push_back(mk(cyc, 2, 0, 0)); n_err++; end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic cmp_events(input string nm);
      chk({nm, " event count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         n_chk++;
         if (act_q[i].cyc != exp_q[i].cyc || act_q[i].kind != exp_q[i].kind ||
             act_q[i].a != exp_q[i].a || act_q[i].d != exp_q[i].d) begin
            n_fail++;
            $display("FAIL %s ev%0d: got cyc=%0d kind=%0d a=0x%0h d=0x%0h, expected cyc=%0d kind=%0d a=0x%0h d=0x%0h",
                     nm, i, act_q[i].cyc, act_q[i].kind, act_q[i].a, act_q[i].d,
                     exp_q[i].cyc, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
         end
      end
      act_q.delete();
      exp_q.delete();
   endtask

   // Packet-level reference: what a packet must produce, and when, relative to its first dibit.
   task automatic model(input int start, input int a, input int adib, input int np, input int extra);
      int len;
      len = adib + 4 * np + extra;
      if (adib < 12) exp_q.push_back(mk(start + 1 + len, 2, 0, 0));
      else if (a >= FP) exp_q.push_back(mk(start + 12, 2, 0, 0));
      else begin
         for (int k = 0; k < np; k++) exp_q.push_back(mk(start + 16 + 4 * k, 0, (a + k) % FP, int'(pix_q[k])));
         exp_q.push_back(mk(start + 1 + len, (extra % 4 != 0) ? 2 : 1, 0, 0));
      end
   endtask

   // Called at a negedge; pixels come from pix_q.
   task automatic send(input int a, input int adib, input int np, input int extra, input int gap);
      logic [1:0]  dq[$];
      logic [23:0] av;
      logic [7:0]  pb;
      av = a[23:0];
      for (int i = 0; i < adib; i++) dq.push_back(av[2*i +: 2]);
      for (int k = 0; k < np; k++) begin
         pb = pix_q[k];
         for (int j = 0; j < 4; j++) dq.push_back(pb[2*j +: 2]);
      end
      for (int e = 0; e < extra; e++) dq.push_back(2'($urandom_range(0, 3)));
      model(cyc, a, adib, np, extra);
      foreach (dq[i]) begin axiiv = 1'b1; axiid = dq[i]; @(negedge clk); end
      axiiv = 1'b0; axiid = 2'b00;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      tbl[0] = '{32'h10,     12, 2, 8'hE4, 8'h1B, 0, 1, 2, 1, 0, 32'h11,  32'h1B};
      tbl[1] = '{32'h20,     12, 1, 8'hAA, 8'h00, 0, 3, 1, 1, 0, 32'h20,  32'hAA};
      tbl[2] = '{32'hFFFFFF, 12, 2, 8'h12, 8'h34, 0, 2, 0, 0, 1, 32'h20,  32'hAA};
      tbl[3] = '{76799,      12, 2, 8'h0F, 8'hF0, 0, 2, 2, 1, 0, 32'h0,   32'hF0};
      tbl[4] = '{5,          12, 1, 8'h5A, 8'h00, 2, 2, 1, 0, 1, 32'h5,   32'h5A};
      tbl[5] = '{100,        12, 0, 8'h00, 8'h00, 0, 2, 0, 1, 0, 32'h5,   32'h5A};
      tbl[6] = '{32'h123,     7, 0, 8'h00, 8'h00, 0, 2, 0, 0, 1, 32'h5,   32'h5A};
      tbl[7] = '{FP,         12, 1, 8'h77, 8'h00, 0, 2, 0, 0, 1, 32'h5,   32'h5A};

      #2 rst_n = 1'b0;
      #1;
      chk("reset pixel_out", pixel_out, 0);
      chk("reset pixel_addr_out", pixel_addr_out, 0);
      chk("reset pixel_we", pixel_we, 0);
      chk("reset pkt_done", pkt_done, 0);
      chk("reset pkt_err", pkt_err, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         int w0, d0, e0;
         pix_q.delete();
         if (tbl[v].np > 0) pix_q.push_back(tbl[v].p0);
         if (tbl[v].np > 1) pix_q.push_back(tbl[v].p1);
         w0 = n_we; d0 = n_done; e0 = n_err;
         send(tbl[v].a, tbl[v].adib, tbl[v].np, tbl[v].extra, tbl[v].gap);
         chk($sformatf("vec%0d writes", v), n_we - w0, tbl[v].e_we);
         chk($sformatf("vec%0d pkt_done", v), n_done - d0, tbl[v].e_done);
         chk($sformatf("vec%0d pkt_err", v), n_err - e0, tbl[v].e_err);
         chk($sformatf("vec%0d held addr", v), pixel_addr_out, tbl[v].e_la);
         chk($sformatf("vec%0d held pixel", v), pixel_out, tbl[v].e_ld);
         cmp_events($sformatf("vec%0d", v));
      end

      for (int r = 0; r < 40; r++) begin
         int a, adib, np, extra, sel;
         sel = $urandom_range(0, 9);
         if (sel < 6)      a = $urandom_range(0, FP - 1);
         else if (sel < 8) a = FP - 1 - $urandom_range(0, 2);
         else              a = $urandom_range(FP, 24'hFFFFFF);
         adib  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 11) : 12;
         np    = (adib < 12) ? 0 : $urandom_range(0, 4);
         extra = (adib < 12 || $urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 3);
         pix_q.delete();
         for (int k = 0; k < np; k++) pix_q.push_back(8'($urandom_range(0, 255)));
         send(a, adib, np, extra, $urandom_range(1, 3));
         cmp_events($sformatf("rnd%0d", r));
      end

      // Reset mid-pixel: one completed write, then the packet must vanish silently.
      rq.delete();
      for (int i = 0; i < 12; i++) rq.push_back(2'((32'h40 >> (2 * i)) & 3));
      for (int j = 0; j < 4; j++)  rq.push_back(2'((32'h11 >> (2 * j)) & 3));
      rq.push_back(2'b10); rq.push_back(2'b00);
      start = cyc;
      exp_q.push_back(mk(start + 16, 0, 32'h40, 32'h11));
      foreach (rq[i]) begin axiiv = 1'b1; axiid = rq[i]; @(negedge clk); end
      axiid = 2'b01;
      #2 rst_n = 1'b0;
      #1;
      chk("midpkt reset pixel_out", pixel_out, 0);
      chk("midpkt reset pixel_addr_out", pixel_addr_out, 0);
      chk("midpkt reset pixel_we", pixel_we, 0);
      chk("midpkt reset pkt_done", pkt_done, 0);
      chk("midpkt reset pkt_err", pkt_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin axiid = 2'($urandom_range(0, 3)); @(negedge clk); end
      axiiv = 1'b0;
      repeat (3) @(negedge clk);
      cmp_events("midpkt reset");

      pix_q.delete();
      pix_q.push_back(8'h3C);
      send(32'h50, 12, 1, 0, 2);
      cmp_events("post reset");
      chk("post reset pixel_out", pixel_out, 32'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
